// File: rtl/restoring_divider_ctrl_if.sv
// restoring_divider_ctrl_if
//
// Groups the divider's request/result signals into one bundle. The operand
// producer uses the master modport and the divider uses the slave modport.
//
// Signals:
//   start        request pulse from the producer
//   dividend     numerator, only meaningful while start is high
//   divisor      denominator, only meaningful while start is high
//   busy         divider is iterating
//   done         one-cycle pulse, result fields are valid
//   quotient     result quotient, held until the next done
//   remainder    result remainder, held until the next done
//   div_by_zero  last completed request had a zero divisor
interface restoring_divider_ctrl_if #(
   parameter int SIZE = 4
);

   logic            start;
   logic [SIZE-1:0] dividend;
   logic [SIZE-1:0] divisor;
   logic            busy;
   logic            done;
   logic [SIZE-1:0] quotient;
   logic [SIZE-1:0] remainder;
   logic            div_by_zero;

   modport master (
      output start,
      output dividend,
      output divisor,
      input  busy,
      input  done,
      input  quotient,
      input  remainder,
      input  div_by_zero
   );

   modport slave (
      input  start,
      input  dividend,
      input  divisor,
      output busy,
      output done,
      output quotient,
      output remainder,
      output div_by_zero
   );

endinterface

// File: rtl/restoring_divider_ctrl.sv
// restoring_divider_ctrl
//
// Multi-cycle unsigned restoring divider. One trial subtraction per clock is
// performed on a single shared param_subtractor, so a division takes SIZE busy
// cycles followed by one done cycle. A zero divisor skips the iteration and
// reports the saturated quotient with the dividend as remainder.
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   restoring_divider_ctrl_if slave: start/dividend/divisor in,
//         busy/done/quotient/remainder/div_by_zero out

// param_subtractor
//
// Plain unsigned WIDTH-bit subtractor a - b. borrow is set when b > a, in
// which case diff holds the two's-complement wrapped result.
//
// Ports:
//   a, b    operands
//   diff    a - b modulo 2**WIDTH
//   borrow  1 when a < b
module param_subtractor #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   // Extending both operands by one zero bit makes the carry-out of the
   // subtraction land in the top bit, which is exactly the borrow.
   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

module restoring_divider_ctrl #(
   parameter int SIZE = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   restoring_divider_ctrl_if.slave  bus
);

   // Wide enough to hold the iteration count SIZE itself.
   localparam int CW = $clog2(SIZE + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;

   // dvd starts as the dividend and is gradually replaced by quotient bits
   // from the right; rem is the partial remainder; dsr is the latched divisor.
   logic [SIZE-1:0] dvd;
   logic [SIZE-1:0] dvd_next;
   logic [SIZE-1:0] dsr;
   logic [SIZE-1:0] dsr_next;
   logic [SIZE-1:0] rem;
   logic [SIZE-1:0] rem_next;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;

   logic [SIZE-1:0] quotient_q;
   logic [SIZE-1:0] quotient_next;
   logic [SIZE-1:0] remainder_q;
   logic [SIZE-1:0] remainder_next;
   logic            dbz_q;
   logic            dbz_next;

   logic [SIZE:0]   shifted;
   logic [SIZE:0]   sub_diff;
   logic            sub_borrow;

   // After a successful subtract the result is always below the divisor, so
   // the top bit of the difference carries no information.
   logic            diff_top_unused;

   assign shifted         = {rem, dvd[SIZE-1]};
   assign diff_top_unused = sub_diff[SIZE];

   // The single shared trial subtractor: shifted partial remainder minus the
   // zero-extended divisor.
   param_subtractor #(
      .WIDTH (SIZE + 1)
   ) u_sub (
      .a      (shifted),
      .b      ({1'b0, dsr}),
      .diff   (sub_diff),
      .borrow (sub_borrow)
   );

   // State and datapath registers. Reset clears everything and abandons any
   // division in flight, so no done follows a mid-operation reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dvd         <= '0;
         dsr         <= '0;
         rem         <= '0;
         count       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state       <= state_next;
         dvd         <= dvd_next;
         dsr         <= dsr_next;
         rem         <= rem_next;
         count       <= count_next;
         quotient_q  <= quotient_next;
         remainder_q <= remainder_next;
         dbz_q       <= dbz_next;
      end
   end

   // Next-state and next-datapath logic. IDLE and DONE share the request
   // acceptance path so a request held through DONE starts immediately,
   // giving one division every SIZE+1 cycles.
   always_comb begin
      state_next     = state;
      dvd_next       = dvd;
      dsr_next       = dsr;
      rem_next       = rem;
      count_next     = count;
      quotient_next  = quotient_q;
      remainder_next = remainder_q;
      dbz_next       = dbz_q;

      unique case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               if (bus.divisor != '0) begin
                  dvd_next   = bus.dividend;
                  dsr_next   = bus.divisor;
                  rem_next   = '0;
                  count_next = CW'(SIZE);
                  state_next = BUSY;
               end else begin
                  quotient_next  = '1;
                  remainder_next = bus.dividend;
                  dbz_next       = 1'b1;
                  state_next     = DONE;
               end
            end else begin
               state_next = IDLE;
            end
         end

         BUSY: begin
            // No borrow: keep the difference and record a 1. Borrow: restore
            // the shifted remainder and record a 0.
            if (sub_borrow) begin
               rem_next = shifted[SIZE-1:0];
            end else begin
               rem_next = sub_diff[SIZE-1:0];
            end
            dvd_next   = {dvd[SIZE-2:0], ~sub_borrow};
            count_next = count - CW'(1);

            // Last iteration: publish the final quotient and remainder so
            // they are already valid in the done cycle.
            if (count == CW'(1)) begin
               quotient_next  = dvd_next;
               remainder_next = rem_next;
               dbz_next       = 1'b0;
               state_next     = DONE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.busy        = (state == BUSY);
   assign bus.done        = (state == DONE);
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// tb_restoring_divider_ctrl
//
// Self-checking bench for restoring_divider_ctrl with SIZE=4. Covers reset
// values, a table of fixed vectors, an exhaustive and a random sweep against
// a plain / and % model, and the multi-cycle handshake corner cases.
module tb_restoring_divider_ctrl;

   localparam int SIZE = 4;
   localparam int MAXV = (1 << SIZE) - 1;

   logic clk = 1'b0;
   logic rst;

   int total = 0;
   int bad   = 0;

   restoring_divider_ctrl_if #(.SIZE(SIZE)) bus ();

   restoring_divider_ctrl #(
      .SIZE (SIZE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int dividend;
      int divisor;
      int exp_q;
      int exp_r;
      int exp_dz;
      int exp_lat;
   } vec_t;

   vec_t vecs [8];

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference behaviour from the arithmetic definition of division.
   function automatic void model(input int a, input int b,
                                 output int q, output int r, output int dz, output int lat);
      if (b == 0) begin
         q   = MAXV;
         r   = a;
         dz  = 1;
         lat = 1;
      end else begin
         q   = a / b;
         r   = a % b;
         dz  = 0;
         lat = SIZE + 1;
      end
   endfunction

   // Presents one request for a single edge. Entered and left at #1 after a
   // rising edge; on return we are in the first cycle after acceptance.
   task automatic applyStimulus(input int a, input int b);
      bus.dividend = SIZE'(a);
      bus.divisor  = SIZE'(b);
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
   endtask

   // Waits (bounded) for done. lat is the cycle index, counted from the
   // acceptance edge, in which done is seen; busy_cnt counts busy cycles.
   task automatic waitDone(input string name, input int start_idx,
                           output int lat, output int busy_cnt);
      lat      = start_idx;
      busy_cnt = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.busy === 1'b1) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (bus.done !== 1'b1) begin
         total++;
         bad++;
         $display("[TB] FAIL %s timeout: done not seen within %0d cycles", name, lat);
      end
   endtask

   task automatic runOp(input string name, input int a, input int b,
                        input int eq, input int er, input int edz, input int elat);
      int lat;
      int bc;
      applyStimulus(a, b);
      waitDone(name, 1, lat, bc);
      checkOutput({name, " latency"}, lat, elat);
      checkOutput({name, " busy cycles"}, bc, elat - 1);
      checkOutput({name, " quotient"}, int'(bus.quotient), eq);
      checkOutput({name, " remainder"}, int'(bus.remainder), er);
      checkOutput({name, " div_by_zero"}, int'(bus.div_by_zero), edz);
      @(posedge clk);
      #1;
      checkOutput({name, " done width"}, int'(bus.done), 0);
   endtask

   task automatic runModel(input string name, input int a, input int b);
      int q;
      int r;
      int dz;
      int lat;
      model(a, b, q, r, dz, lat);
      runOp(name, a, b, q, r, dz, lat);
   endtask

   // Counts done pulses over a window where none may occur.
   task automatic watchNoDone(input string name, input int cycles);
      int n;
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) n++;
      end
      checkOutput({name, " spurious done"}, n, 0);
   endtask

   initial begin
      int lat;
      int bc;

      vecs[0] = '{13,  3,  4, 1, 0, 5};
      vecs[1] = '{15,  1, 15, 0, 0, 5};
      vecs[2] = '{ 5,  7,  0, 5, 0, 5};
      vecs[3] = '{15, 15,  1, 0, 0, 5};
      vecs[4] = '{ 9,  0, 15, 9, 1, 1};
      vecs[5] = '{ 0,  5,  0, 0, 0, 5};
      vecs[6] = '{ 0,  0, 15, 0, 1, 1};
      vecs[7] = '{14,  4,  3, 2, 0, 5};

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy", int'(bus.busy), 0);
      checkOutput("reset done", int'(bus.done), 0);
      checkOutput("reset quotient", int'(bus.quotient), 0);
      checkOutput("reset remainder", int'(bus.remainder), 0);
      checkOutput("reset div_by_zero", int'(bus.div_by_zero), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         runOp($sformatf("vec%0d %0d/%0d", i, vecs[i].dividend, vecs[i].divisor),
               vecs[i].dividend, vecs[i].divisor,
               vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dz, vecs[i].exp_lat);
      end

      // A second request two cycles into a division must be ignored.
      applyStimulus(13, 3);
      @(posedge clk);
      #1;
      bus.dividend = 4'd2;
      bus.divisor  = 4'd1;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      waitDone("busy start", 3, lat, bc);
      checkOutput("busy start latency", lat, 5);
      checkOutput("busy start quotient", int'(bus.quotient), 4);
      checkOutput("busy start remainder", int'(bus.remainder), 1);
      watchNoDone("busy start", 8);

      // Back-to-back: start held high, new operands presented in DONE.
      bus.dividend = 4'd13;
      bus.divisor  = 4'd3;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      waitDone("b2b first", 1, lat, bc);
      checkOutput("b2b first latency", lat, 5);
      checkOutput("b2b first quotient", int'(bus.quotient), 4);
      checkOutput("b2b first remainder", int'(bus.remainder), 1);
      bus.dividend = 4'd14;
      bus.divisor  = 4'd4;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      waitDone("b2b second", 1, lat, bc);
      checkOutput("b2b second spacing", lat, 5);
      checkOutput("b2b second quotient", int'(bus.quotient), 3);
      checkOutput("b2b second remainder", int'(bus.remainder), 2);
      @(posedge clk);
      #1;

      // Reset in the middle of a division clears outputs and drops the op.
      applyStimulus(13, 3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midreset busy", int'(bus.busy), 0);
      checkOutput("midreset done", int'(bus.done), 0);
      checkOutput("midreset quotient", int'(bus.quotient), 0);
      checkOutput("midreset remainder", int'(bus.remainder), 0);
      watchNoDone("midreset", 8);
      runOp("post reset 6/2", 6, 2, 3, 0, 0, 5);

      for (int a = 0; a <= MAXV; a++) begin
         for (int b = 0; b <= MAXV; b++) begin
            runModel($sformatf("sweep %0d/%0d", a, b), a, b);
         end
      end

      for (int i = 0; i < 40; i++) begin
         int a;
         int b;
         a = int'($urandom_range(0, MAXV));
         b = int'($urandom_range(0, MAXV));
         runModel($sformatf("rand %0d/%0d", a, b), a, b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
